// File: rtl/maxpool_layer_1_pkg.sv
// Shared constants and helpers for the first pooling layer and the stages
// that follow it.
package maxpool_layer_1_pkg;

  localparam int DATA_W  = 32;
  localparam int FMAP1_W = 24;
  localparam int FMAP1_H = 24;
  localparam int POOL1_W = 12;
  localparam int NUM_CH1 = 6;

  // Unsigned maximum of two pixels; ties return either operand unchanged.
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_layer_1_pool_channel.sv
// One channel of 2x2 stride-2 max pooling. The phase strobes and the line
// buffer address come from the shared counters in the top.
module pool_channel #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 12,
  parameter int AW     = 4
) (
  input  logic              clk_global,
  input  logic              reset_layer,
  input  logic              wr_h,
  input  logic              wr_lb,
  input  logic              emit,
  input  logic [AW-1:0]     lb_addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] pool_out
);
  import maxpool_layer_1_pkg::*;

  logic [DATA_W-1:0] h;
  logic [DATA_W-1:0] lb [DEPTH];
  logic [DATA_W-1:0] pair_max;

  assign pair_max = umax(h, din);

  // Hold the even-column pixel until its odd-column partner arrives.
  always_ff @(posedge clk_global or negedge reset_layer) begin
    if (!reset_layer) h <= '0;
    else if (wr_h)    h <= din;
  end

  // Even-row pair maxima; every entry is rewritten before the odd row reads it.
  always_ff @(posedge clk_global) begin
    if (wr_lb) lb[lb_addr] <= pair_max;
  end

  // Final window maximum, held until the next window completes.
  always_ff @(posedge clk_global or negedge reset_layer) begin
    if (!reset_layer) pool_out <= '0;
    else if (emit)    pool_out <= umax(lb[lb_addr], pair_max);
  end

endmodule

// File: rtl/maxpool_layer_1.sv
// 2x2 stride-2 max pooling over six channels in lockstep. Raster counters
// decode the window phase and drive shared strobes into each channel.
module maxpool_layer_1 #(
  parameter int DATA_W = 32,
  parameter int FMAP_W = 24,
  parameter int FMAP_H = 24
) (
  input  logic              clk_global,
  input  logic              reset_layer,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  output logic [DATA_W-1:0] pool_out1,
  output logic [DATA_W-1:0] pool_out2,
  output logic [DATA_W-1:0] pool_out3,
  output logic [DATA_W-1:0] pool_out4,
  output logic [DATA_W-1:0] pool_out5,
  output logic [DATA_W-1:0] pool_out6,
  output logic              out_valid,
  output logic [7:0]        pool_idx,
  output logic              frame_done
);
  import maxpool_layer_1_pkg::*;

  localparam int CW     = $clog2(FMAP_W);
  localparam int RW     = $clog2(FMAP_H);
  localparam int POOL_W = FMAP_W / 2;
  localparam int AW     = $clog2(POOL_W);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last_col;
  logic              last_row;
  logic              wr_h;
  logic              wr_lb;
  logic              emit;
  logic [AW-1:0]     lb_addr;
  logic [7:0]        idx_next;
  logic [DATA_W-1:0] ch_in  [NUM_CH1];
  logic [DATA_W-1:0] ch_out [NUM_CH1];

  assign last_col = (col == CW'(FMAP_W - 1));
  assign last_row = (row == RW'(FMAP_H - 1));
  assign wr_h     = in_valid && !col[0];
  assign wr_lb    = in_valid && !row[0] && col[0];
  assign emit     = in_valid &&  row[0] && col[0];
  assign lb_addr  = AW'(col >> 1);
  assign idx_next = 8'(row >> 1) * 8'(POOL_W) + 8'(col >> 1);

  assign ch_in[0] = in1;
  assign ch_in[1] = in2;
  assign ch_in[2] = in3;
  assign ch_in[3] = in4;
  assign ch_in[4] = in5;
  assign ch_in[5] = in6;

  assign pool_out1 = ch_out[0];
  assign pool_out2 = ch_out[1];
  assign pool_out3 = ch_out[2];
  assign pool_out4 = ch_out[3];
  assign pool_out5 = ch_out[4];
  assign pool_out6 = ch_out[5];

  // Raster position of the next accepted pixel; wraps seamlessly into the next frame.
  always_ff @(posedge clk_global or negedge reset_layer) begin
    if (!reset_layer) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output handshake: one pulse per completed window, index held between beats.
  always_ff @(posedge clk_global or negedge reset_layer) begin
    if (!reset_layer) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      pool_idx   <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && last_col && last_row;
      if (emit) pool_idx <= idx_next;
    end
  end

  for (genvar g = 0; g < NUM_CH1; g++) begin : g_ch
    pool_channel #(
      .DATA_W (DATA_W),
      .DEPTH  (POOL_W),
      .AW     (AW)
    ) u_channel (
      .clk_global  (clk_global),
      .reset_layer (reset_layer),
      .wr_h        (wr_h),
      .wr_lb       (wr_lb),
      .emit        (emit),
      .lb_addr     (lb_addr),
      .din         (ch_in[g]),
      .pool_out    (ch_out[g])
    );
  end

endmodule

// File: tb/tb_maxpool_layer_1.sv
// Scoreboard bench for maxpool_layer_1: expected windows are pushed when the
// fourth pixel of a window is driven and compared when out_valid appears.
module tb_maxpool_layer_1;

  localparam int DW = 32;
  localparam int W  = 24;
  localparam int H  = 24;
  localparam int PW = 12;

  logic          clk_global = 1'b0;
  logic          reset_layer = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0, in6 = '0;
  logic [DW-1:0] pool_out1, pool_out2, pool_out3, pool_out4, pool_out5, pool_out6;
  logic          out_valid;
  logic [7:0]    pool_idx;
  logic          frame_done;

  typedef struct packed {
    logic [7:0]         idx;
    logic [5:0][DW-1:0] val;
    logic               done;
    logic [31:0]        cyc;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            assertCount = 0;
  int            failCount   = 0;
  int            outCount    = 0;
  int            doneCount   = 0;
  int            cyc         = 0;
  logic [DW-1:0] pix [6][H][W];

  always #5 clk_global = ~clk_global;

  always @(posedge clk_global) cyc <= cyc + 1;

  maxpool_layer_1 dut (
    .clk_global  (clk_global),
    .reset_layer (reset_layer),
    .in_valid    (in_valid),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .in4         (in4),
    .in5         (in5),
    .in6         (in6),
    .pool_out1   (pool_out1),
    .pool_out2   (pool_out2),
    .pool_out3   (pool_out3),
    .pool_out4   (pool_out4),
    .pool_out5   (pool_out5),
    .pool_out6   (pool_out6),
    .out_valid   (out_valid),
    .pool_idx    (pool_idx),
    .frame_done  (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // mode 0: ramp (offset + row*24 + col + channel); mode 1: max-position frame
  function automatic logic [DW-1:0] pixelFor(input int mode, input int ch, input int r,
                                             input int c, input int offset);
    int pos;
    int rot;
    logic [DW-1:0] v;
    if (mode == 0) return DW'(offset + r * W + c + ch);
    if (r >= 2 || c >= 2) return '0;
    pos = r * 2 + c;
    v = '0;
    if (ch < 4) begin
      rot = (pos - ch + 4) % 4;
      case (rot)
        0: v = 32'd9;
        1: v = 32'd5;
        2: v = 32'd3;
        default: v = 32'd7;
      endcase
    end else if (ch == 4) begin
      v = (pos == 1) ? 32'h0100_0000 : 32'h0;
    end else begin
      case (pos)
        0: v = 32'h0100_0000;
        3: v = 32'h00FF_FFFF;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic randomInputs();
    in1 = $urandom; in2 = $urandom; in3 = $urandom;
    in4 = $urandom; in5 = $urandom; in6 = $urandom;
  endtask

  // Drive nBeats pixels starting at (0,0), with 0..maxGap idle cycles before each.
  task automatic applyStimulus(input int mode, input int offset, input int maxGap, input int nBeats);
    exp_t e;
    for (int n = 0; n < nBeats; n++) begin
      int r;
      int c;
      r = n / W;
      c = n % W;
      if (maxGap > 0) begin
        int g;
        g = $urandom_range(maxGap, 0);
        repeat (g) begin
          in_valid = 1'b0;
          randomInputs();
          @(posedge clk_global); #1;
        end
      end
      for (int k = 0; k < 6; k++) pix[k][r][c] = pixelFor(mode, k, r, c, offset);
      in1 = pix[0][r][c]; in2 = pix[1][r][c]; in3 = pix[2][r][c];
      in4 = pix[3][r][c]; in5 = pix[4][r][c]; in6 = pix[5][r][c];
      in_valid = 1'b1;
      @(posedge clk_global); #1;
      in_valid = 1'b0;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.idx  = 8'((r / 2) * PW + (c / 2));
        for (int k = 0; k < 6; k++)
          e.val[k] = max2(max2(pix[k][r-1][c-1], pix[k][r-1][c]),
                          max2(pix[k][r][c-1],   pix[k][r][c]));
        e.done = (r == H - 1) && (c == W - 1);
        e.cyc  = 32'(cyc);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    repeat (4) @(posedge clk_global);
    #1;
    checkOutput(tag, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  // Monitor: every out_valid beat must match the oldest pending window.
  always @(negedge clk_global) begin
    if (frame_done) checkOutput("done_needs_valid", 64'(out_valid), 64'd1);
    if (out_valid) begin
      outCount++;
      if (frame_done) doneCount++;
      if (sbq.size() == 0) begin
        checkOutput("spurious_valid_pending", 64'(sbq.size()), 64'd1);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("pool_idx",   64'(pool_idx),   64'(mon_e.idx));
        checkOutput("pool_out1",  64'(pool_out1),  64'(mon_e.val[0]));
        checkOutput("pool_out2",  64'(pool_out2),  64'(mon_e.val[1]));
        checkOutput("pool_out3",  64'(pool_out3),  64'(mon_e.val[2]));
        checkOutput("pool_out4",  64'(pool_out4),  64'(mon_e.val[3]));
        checkOutput("pool_out5",  64'(pool_out5),  64'(mon_e.val[4]));
        checkOutput("pool_out6",  64'(pool_out6),  64'(mon_e.val[5]));
        checkOutput("frame_done", 64'(frame_done), 64'(mon_e.done));
        checkOutput("latency",    64'(cyc),        64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int o0;
    int d0;

    $display("[TB] reset hold with random activity");
    reset_layer = 1'b0;
    repeat (20) begin
      in_valid = 1'($urandom);
      randomInputs();
      @(posedge clk_global); #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    checkOutput("rst_pool_idx",   64'(pool_idx),   64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst_pool_out1",  64'(pool_out1),  64'd0);
    checkOutput("rst_pool_out6",  64'(pool_out6),  64'd0);
    reset_layer = 1'b1;
    @(posedge clk_global); #1;

    $display("[TB] ramp frame");
    o0 = outCount; d0 = doneCount;
    applyStimulus(0, 0, 0, W * H);
    waitDrain("ramp_drain");
    checkOutput("ramp_count", 64'(outCount - o0), 64'd144);
    checkOutput("ramp_done",  64'(doneCount - d0), 64'd1);

    $display("[TB] max-position frame");
    o0 = outCount;
    applyStimulus(1, 0, 0, W * H);
    waitDrain("maxpos_drain");
    checkOutput("maxpos_count", 64'(outCount - o0), 64'd144);

    $display("[TB] gapped ramp frame");
    o0 = outCount; d0 = doneCount;
    applyStimulus(0, 0, 5, W * H);
    waitDrain("gap_drain");
    checkOutput("gap_count", 64'(outCount - o0), 64'd144);
    checkOutput("gap_done",  64'(doneCount - d0), 64'd1);

    $display("[TB] mid-frame reset at row 7 col 5");
    applyStimulus(0, 5000, 0, 7 * W + 6);
    @(negedge clk_global); #1;
    checkOutput("prerst_pending", 64'(sbq.size()), 64'd0);
    reset_layer = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_pool_idx",  64'(pool_idx),  64'd0);
    checkOutput("midrst_pool_out1", 64'(pool_out1), 64'd0);
    checkOutput("midrst_pool_out6", 64'(pool_out6), 64'd0);
    sbq.delete();
    @(posedge clk_global); #1;
    reset_layer = 1'b1;
    o0 = outCount; d0 = doneCount;
    applyStimulus(0, 0, 0, W * H);
    waitDrain("midrst_drain");
    checkOutput("midrst_count", 64'(outCount - o0), 64'd144);
    checkOutput("midrst_done",  64'(doneCount - d0), 64'd1);

    $display("[TB] back-to-back frames");
    o0 = outCount; d0 = doneCount;
    applyStimulus(0, 0, 0, W * H);
    applyStimulus(0, 1000, 0, W * H);
    waitDrain("b2b_drain");
    checkOutput("b2b_count", 64'(outCount - o0), 64'd288);
    checkOutput("b2b_done",  64'(doneCount - d0), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/maxpool_layer_1.md
# maxpool_layer_1

- Downstream neighbour of the first convolution layer.
- Takes the six ReLU-clamped q8.24 feature-map streams (24×24 pixels each, raster order, one pixel per channel per valid beat).
- Performs 2×2, stride-2 max pooling on all six channels in lockstep.
- Emits six 12×12 pooled streams, one output beat per completed window, to feed the second convolution layer.

## Interface
Parameters:
- DATA_W, 32, pixel width; unsigned q8.24, range 0..0x01000000.
- FMAP_W, 24, input feature-map width; must be even.
- FMAP_H, 24, input feature-map height; must be even.

Ports:
- clk_global  in  1  single clock; all logic on its rising edge.
- reset_layer  in  1  asynchronous, active-low reset.
- in_valid  in  1  one input pixel per channel accepted on each edge where high.
- in1..in6  in  DATA_W  channel 1..6 pixels.
- pool_out1..pool_out6  out  DATA_W  pooled pixel per channel; held between beats.
- out_valid  out  1  one-cycle pulse per pooled pixel.
- pool_idx  out  8  raster index (0..143) of the current pooled pixel.
- frame_done  out  1  pulses together with out_valid for pool_idx = 143.

## Operation
- Two input counters advance only on in_valid beats:
  - col: 0..FMAP_W-1.
  - row: 0..FMAP_H-1.
  - col wraps to 0 and increments row; after the last pixel both wrap to 0, so the next frame follows with no gap.
- Per channel:
  - hold register h.
  - line buffer lb of FMAP_W/2 entries, addressed by col>>1.
- Even row, even col: h <= in.
- Even row, odd col: lb[col>>1] <= max(h, in).
- Odd row, even col: h <= in.
- Odd row, odd col:
  - pool_out <= max(lb[col>>1], h, in).
  - out_valid <= 1.
  - pool_idx <= (row>>1)*(FMAP_W/2) + (col>>1).
- Comparisons are unsigned DATA_W; no arithmetic, no width growth.
- Ties select any equal value; the result is identical either way.
- Every lb entry is written on an even row before it is read on the following odd row. The line buffer therefore needs no reset or clear.
- Idle cycles (in_valid low) anywhere, including inside a window, change no state other than dropping out_valid and frame_done.
- No back-pressure: the downstream stage must accept every out_valid beat.

## Timing
- All outputs are registered.
- Reset values: pool_out1..6 = 0, out_valid = 0, pool_idx = 0, frame_done = 0, row = col = 0, all h = 0.
- Latency: out_valid is high in the cycle after the edge that accepts the fourth pixel of a window (odd row, odd col).
- out_valid and frame_done are high for exactly one cycle per window.
- Max output rate: one pooled beat per 2 input beats on odd rows; none on even rows.
- Reset asserted mid-frame:
  - All counters and outputs return to reset values immediately (asynchronous).
  - The next accepted pixel after deassertion is treated as row 0, col 0.
  - No output derived from pre-reset data may ever appear.
- Deassertion is synchronised externally; the block only requires that it be clean relative to clk_global.

## Structure
- Shared package (layer-common):
  - DATA_W.
  - FMAP1_W = FMAP1_H = 24.
  - POOL1_W = 12.
  - NUM_CH1 = 6.
  - Unsigned max function, reused by later pooling layers.
- Sub-module pool_channel, instantiated six times:
  - Contains h, lb, the comparator tree and the output register.
  - Driven by shared phase strobes from the top: wr_h, wr_lb, emit, and lb address.
- The top holds the row/col counters, the strobe decode, pool_idx, out_valid and frame_done.

## Test plan
- Reset: hold reset_layer low with random in* and in_valid toggling → all outputs 0, out_valid never high; after release the first beat is treated as (0,0).
- Ramp frame: 576 back-to-back beats, in1 = row*24+col, in2..6 = in1+k → exactly 144 out_valid pulses; beat n = 12r+c gives pool_out1 = (2r+1)*24+2c+1 and pool_idx = n; frame_done only with n = 143.
- Max position: window (0,0) on ch1..4 contains values {9,5,3,7} with 9 rotated through all four positions, all other pixels 0 → pool_out1..4 = 9 at idx 0; boundaries 0 and 0x01000000 mixed → output 0x01000000.
- Gapped input: ramp frame with 0–5 random idle cycles between beats → values and idx identical to the ramp frame; each out_valid exactly one cycle after the fourth beat of its window.
- Mid-frame reset: pulse reset_layer low at row 7 col 5, then send a full ramp frame → exactly 144 beats, all correct, none from pre-reset data.
- Back-to-back frames: two ramp frames with no gap, the second offset by +1000 → second frame's pool_idx restarts at 0 with values offset by 1000; two frame_done pulses total.
